// File: rtl/scc68070_irq_ctrl.sv
// rtl/scc68070_irq_ctrl.sv - SCC68070 interrupt arbiter, IPL driver and IACK vector generator
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   ext_in2/4/5            external level-sensitive requests at fixed levels 2/4/5
//   onchip_pend[5:0]       on-chip requests: INT1, INT2, timer, UART RX, UART TX, I2C
//   onchip_lvl[17:0]       3-bit level per on-chip source, 0 disables it
//   iack, iack_lvl[2:0]    CPU acknowledge cycle and the level being acknowledged
//   ipl[2:0]               registered requested level to the core
//   vector[7:0]            acknowledge vector, valid while vector_valid=1
//   vector_valid           IACK read enable
//   autovector             latched winner is external
//   ack_src[5:0]           one-cycle clear pulse for the acknowledged on-chip source
module scc68070_irq_ctrl #(
    parameter logic [7:0] ONCHIP_BASE  = 8'd56,
    parameter logic [7:0] AUTO_BASE    = 8'd24,
    parameter logic [7:0] SPURIOUS_VEC = 8'd24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ext_in2,
    input  logic        ext_in4,
    input  logic        ext_in5,
    input  logic [5:0]  onchip_pend,
    input  logic [17:0] onchip_lvl,
    input  logic        iack,
    input  logic [2:0]  iack_lvl,
    output logic [2:0]  ipl,
    output logic [7:0]  vector,
    output logic        vector_valid,
    output logic        autovector,
    output logic [5:0]  ack_src
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESENT = 2'd1;
    localparam logic [1:0] S_ACK     = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0] state_q, state_d;
    logic [2:0] ipl_q, ipl_d;
    logic [7:0] vector_q, vector_d;
    logic       vector_valid_q, vector_valid_d;
    logic       autovector_q, autovector_d;
    logic [5:0] ack_src_q, ack_src_d;
    logic [2:0] lat_lvl_q, lat_lvl_d;
    logic [2:0] lat_src_q, lat_src_d;
    logic       lat_ext_q, lat_ext_d;

    logic [2:0] cand_lvl;
    logic [2:0] cand_src;
    logic       cand_ext;
    logic [2:0] src_lvl;

    // Externals are seeded first; an on-chip source takes over on a strictly
    // higher level, or on an equal level held by an external. Ascending scan
    // with strict compare leaves the lowest-index on-chip source on ties.
    always_comb begin
        cand_lvl = 3'd0;
        cand_src = 3'd0;
        cand_ext = 1'b0;
        src_lvl  = 3'd0;
        if (ext_in2) begin
            cand_lvl = 3'd2;
            cand_ext = 1'b1;
        end
        if (ext_in4) begin
            cand_lvl = 3'd4;
            cand_ext = 1'b1;
        end
        if (ext_in5) begin
            cand_lvl = 3'd5;
            cand_ext = 1'b1;
        end
        for (int i = 0; i < 6; i++) begin
            src_lvl = onchip_lvl[3*i +: 3];
            if (onchip_pend[i] && (src_lvl != 3'd0) &&
                ((src_lvl > cand_lvl) || ((src_lvl == cand_lvl) && cand_ext))) begin
                cand_lvl = src_lvl;
                cand_src = 3'(i);
                cand_ext = 1'b0;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ipl_d          = ipl_q;
        vector_d       = vector_q;
        vector_valid_d = vector_valid_q;
        autovector_d   = autovector_q;
        ack_src_d      = 6'd0;
        lat_lvl_d      = lat_lvl_q;
        lat_src_d      = lat_src_q;
        lat_ext_d      = lat_ext_q;
        case (state_q)
            S_IDLE: begin
                if (iack) begin
                    // Acknowledge with nothing presented is answered as spurious.
                    state_d        = S_ACK;
                    vector_d       = SPURIOUS_VEC;
                    autovector_d   = 1'b0;
                    vector_valid_d = 1'b1;
                end else if (cand_lvl != 3'd0) begin
                    state_d   = S_PRESENT;
                    ipl_d     = cand_lvl;
                    lat_lvl_d = cand_lvl;
                    lat_src_d = cand_src;
                    lat_ext_d = cand_ext;
                end
            end
            S_PRESENT: begin
                if (iack) begin
                    // The latch from the previous cycle is what gets acknowledged.
                    state_d        = S_ACK;
                    vector_valid_d = 1'b1;
                    if (iack_lvl == lat_lvl_q) begin
                        vector_d     = (lat_ext_q ? AUTO_BASE : ONCHIP_BASE) + {5'd0, lat_lvl_q};
                        autovector_d = lat_ext_q;
                        ack_src_d    = lat_ext_q ? 6'd0 : (6'd1 << lat_src_q);
                    end else begin
                        vector_d     = SPURIOUS_VEC;
                        autovector_d = 1'b0;
                    end
                end else if (cand_lvl != 3'd0) begin
                    ipl_d     = cand_lvl;
                    lat_lvl_d = cand_lvl;
                    lat_src_d = cand_src;
                    lat_ext_d = cand_ext;
                end else begin
                    state_d = S_IDLE;
                    ipl_d   = 3'd0;
                end
            end
            S_ACK: begin
                if (!iack) begin
                    state_d        = S_RELEASE;
                    ipl_d          = 3'd0;
                    vector_d       = 8'd0;
                    vector_valid_d = 1'b0;
                    autovector_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                ipl_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ipl_q          <= 3'd0;
            vector_q       <= 8'd0;
            vector_valid_q <= 1'b0;
            autovector_q   <= 1'b0;
            ack_src_q      <= 6'd0;
            lat_lvl_q      <= 3'd0;
            lat_src_q      <= 3'd0;
            lat_ext_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ipl_q          <= ipl_d;
            vector_q       <= vector_d;
            vector_valid_q <= vector_valid_d;
            autovector_q   <= autovector_d;
            ack_src_q      <= ack_src_d;
            lat_lvl_q      <= lat_lvl_d;
            lat_src_q      <= lat_src_d;
            lat_ext_q      <= lat_ext_d;
        end
    end

    assign ipl          = ipl_q;
    assign vector       = vector_q;
    assign vector_valid = vector_valid_q;
    assign autovector   = autovector_q;
    assign ack_src      = ack_src_q;
endmodule

// File: tb/tb_scc68070_irq_ctrl.sv
// tb/tb_scc68070_irq_ctrl.sv - scoreboard testbench for scc68070_irq_ctrl
module tb_scc68070_irq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ext_in2, ext_in4, ext_in5;
    logic [5:0]  onchip_pend;
    logic [17:0] onchip_lvl;
    logic        iack;
    logic [2:0]  iack_lvl;
    logic [2:0]  ipl;
    logic [7:0]  vector;
    logic        vector_valid;
    logic        autovector;
    logic [5:0]  ack_src;

    scc68070_irq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ext_in2(ext_in2), .ext_in4(ext_in4), .ext_in5(ext_in5),
        .onchip_pend(onchip_pend), .onchip_lvl(onchip_lvl),
        .iack(iack), .iack_lvl(iack_lvl),
        .ipl(ipl), .vector(vector), .vector_valid(vector_valid),
        .autovector(autovector), .ack_src(ack_src)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int ipl;
        int vv;
        bit z;
    } ichk_t;
    typedef struct {
        int vec;
        int av;
        int src;
    } vchk_t;

    ichk_t iq[$];
    vchk_t vq[$];
    int    total = 0;
    int    bad   = 0;
    bit    done  = 1'b0;
    bit    mon_done = 1'b0;

    function automatic void chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
        end
    endfunction

    // Monitor: vector expectations are popped on each rising vector_valid,
    // timed ipl/vector_valid expectations are popped on their target cycle.
    initial begin : monitor
        bit    vv_prev;
        vchk_t v;
        ichk_t c;
        vv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (vector_valid && !vv_prev) begin
                if (vq.size() == 0) begin
                    chk("unexpected_vector", 1, 0);
                end else begin
                    v = vq.pop_front();
                    chk("vector", int'(vector), v.vec);
                    chk("autovector", int'(autovector), v.av);
                    chk("ack_src", int'(ack_src), v.src);
                end
            end else if (vector_valid) begin
                chk("ack_src_single_pulse", int'(ack_src), 0);
            end
            vv_prev = vector_valid;
            while (iq.size() > 0 && iq[0].cyc <= cyc) begin
                c = iq.pop_front();
                if (c.cyc != cyc) chk("check_cycle", cyc, c.cyc);
                if (c.ipl >= 0) chk("ipl", int'(ipl), c.ipl);
                chk("vector_valid", int'(vector_valid), c.vv);
                if (c.z) begin
                    chk("zero_vector", int'(vector), 0);
                    chk("zero_autovector", int'(autovector), 0);
                    chk("zero_ack_src", int'(ack_src), 0);
                end
            end
            if (done && !mon_done) begin
                chk("leftover_vector_expect", vq.size(), 0);
                chk("leftover_timed_expect", iq.size(), 0);
                mon_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_i(int d, int i, int v, bit z = 1'b0);
        iq.push_back('{cyc + d, i, v, z});
    endtask

    task automatic exp_v(int vec, int av, int src);
        vq.push_back('{vec, av, src});
    endtask

    initial begin : stim
        rst_n = 1'b0;
        ext_in2 = 1'b0; ext_in4 = 1'b0; ext_in5 = 1'b0;
        onchip_pend = 6'd0;
        onchip_lvl = 18'd0;
        iack = 1'b0;
        iack_lvl = 3'd0;
        repeat (3) tick();
        exp_i(0, 0, 0, 1'b1);

        // Timer at level 6, acknowledged at level 6
        rst_n = 1'b1;
        onchip_lvl[8:6] = 3'd6;
        onchip_pend[2] = 1'b1;
        exp_i(1, 6, 0);
        tick();
        iack = 1'b1; iack_lvl = 3'd6;
        exp_v(62, 0, 6'b000100);
        exp_i(1, 6, 1);
        tick();
        tick();
        onchip_pend[2] = 1'b0; iack = 1'b0;
        exp_i(1, 0, 0);
        tick();
        exp_i(1, 0, 0);
        tick();

        // ext_in4 and UART RX at level 4: on-chip wins, then the external
        ext_in4 = 1'b1;
        onchip_lvl[11:9] = 3'd4;
        onchip_pend[3] = 1'b1;
        exp_i(1, 4, 0);
        tick();
        iack = 1'b1; iack_lvl = 3'd4;
        exp_v(60, 0, 6'b001000);
        tick();
        tick();
        onchip_pend[3] = 1'b0; iack = 1'b0;
        exp_i(1, 0, 0);
        tick();
        exp_i(1, 0, 0);
        tick();
        exp_i(1, 4, 0);
        tick();
        iack = 1'b1;
        exp_v(28, 1, 0);
        tick();
        tick();
        ext_in4 = 1'b0; iack = 1'b0;
        exp_i(1, 0, 0);
        tick();
        tick();

        // ext_in2 pre-empted by I2C at level 7
        ext_in2 = 1'b1;
        exp_i(1, 2, 0);
        tick();
        onchip_lvl[17:15] = 3'd7;
        onchip_pend[5] = 1'b1;
        exp_i(1, 7, 0);
        tick();
        iack = 1'b1; iack_lvl = 3'd7;
        exp_v(63, 0, 6'b100000);
        tick();
        tick();
        onchip_pend[5] = 1'b0; ext_in2 = 1'b0; iack = 1'b0;
        tick();
        tick();
        exp_i(1, 0, 0);
        tick();

        // Level mismatch on ext_in5 gives spurious, ipl returns after release
        ext_in5 = 1'b1;
        exp_i(1, 5, 0);
        tick();
        iack = 1'b1; iack_lvl = 3'd3;
        exp_v(24, 0, 0);
        tick();
        tick();
        iack = 1'b0;
        exp_i(1, 0, 0);
        exp_i(2, 0, 0);
        exp_i(3, 5, 0);
        repeat (3) tick();
        ext_in5 = 1'b0;
        exp_i(1, 0, 0);
        tick();
        tick();

        // Timer request drops on the same edge iack rises
        onchip_pend[2] = 1'b1;
        exp_i(1, 6, 0);
        tick();
        iack = 1'b1; iack_lvl = 3'd6;
        onchip_pend[2] = 1'b0;
        exp_v(62, 0, 6'b000100);
        exp_i(1, 6, 1);
        tick();
        tick();
        iack = 1'b0;
        exp_i(1, 0, 0);
        tick();
        tick();
        exp_i(1, 0, 0);
        tick();

        // Acknowledge with nothing pending
        iack = 1'b1; iack_lvl = 3'd1;
        exp_v(24, 0, 0);
        exp_i(1, 0, 1);
        tick();
        tick();
        iack = 1'b0;
        tick();
        tick();

        // Reset while vector_valid=1, then INT1 at level 3 re-presents
        onchip_lvl[2:0] = 3'd3;
        onchip_pend[0] = 1'b1;
        exp_i(1, 3, 0);
        tick();
        iack = 1'b1; iack_lvl = 3'd3;
        exp_v(59, 0, 6'b000001);
        tick();
        rst_n = 1'b0;
        exp_i(1, 0, 0, 1'b1);
        tick();
        rst_n = 1'b1; iack = 1'b0;
        exp_i(1, 3, 0);
        tick();
        onchip_pend[0] = 1'b0;
        tick();
        tick();

        done = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) tick();
        if (!mon_done) begin
            $display("FAIL monitor_timeout: actual=0 required=1");
            $fatal(1, "monitor did not finish");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
